// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: UART transmitter with run-time baud divisor,
// character length, parity and stop bits, fed by a small FIFO.
module uart_tx_fifo_param #(
    parameter int DATA_W  = 8,
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [3:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              tx_done,
    output logic              busy,
    output logic              bit_tick,
    output logic [FIFO_AW:0]  fifo_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic [FIFO_AW:0]   cnt_d;
    logic               push;
    logic               pop;

    state_t             state_q;
    state_t             state_d;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [DIV_W-1:0]   div_cnt_d;
    logic [DIV_W-1:0]   baud_l_q;
    logic [DIV_W-1:0]   baud_l_d;
    logic [3:0]         nbits_l_q;
    logic [3:0]         nbits_l_d;
    logic [3:0]         bit_idx_q;
    logic [3:0]         bit_idx_d;
    logic               par_en_q;
    logic               par_en_d;
    logic               par_bit_q;
    logic               par_bit_d;
    logic               stop2_l_q;
    logic               stop2_l_d;
    logic               stop_idx_q;
    logic               stop_idx_d;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  shift_d;
    logic               tx_q;
    logic               tx_d;
    logic               done_q;
    logic               done_d;

    logic [DIV_W-1:0]   baud_eff;
    logic [3:0]         nbits_eff;
    logic [DATA_W-1:0]  head;
    logic               head_par;
    logic               bit_end;
    logic               load;

    assign in_ready = (cnt_q != FULL);
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];
    assign bit_end  = (div_cnt_q == baud_l_q);

    assign baud_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;

    always_comb begin
        nbits_eff = data_bits;
        if (data_bits < 4'd5) begin
            nbits_eff = 4'd5;
        end else if (data_bits > 4'(DATA_W)) begin
            nbits_eff = 4'(DATA_W);
        end
    end

    // Parity covers only the bits that will actually be shifted out.
    always_comb begin
        head_par = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(nbits_eff)) begin
                head_par = head_par ^ head[i];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        baud_l_d   = baud_l_q;
        nbits_l_d  = nbits_l_q;
        bit_idx_d  = bit_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_l_d  = stop2_l_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;

        if (state_q != S_IDLE) begin
            div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (cnt_q != '0) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == nbits_l_q - 4'd1) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_l_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (cnt_q != '0) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Pop and latch the frame configuration together.
        if (load) begin
            pop       = 1'b1;
            state_d   = S_START;
            tx_d      = 1'b0;
            div_cnt_d = '0;
            baud_l_d  = baud_eff;
            nbits_l_d = nbits_eff;
            par_en_d  = ^parity_mode;
            par_bit_d = head_par ^ parity_mode[1];
            stop2_l_d = stop2;
            shift_d   = head;
            bit_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            baud_l_q   <= DIV_W'(1);
            nbits_l_q  <= 4'(DATA_W);
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_l_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            baud_l_q   <= baud_l_d;
            nbits_l_q  <= nbits_l_d;
            bit_idx_q  <= bit_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_l_q  <= stop2_l_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign busy     = (state_q != S_IDLE);
    assign bit_tick = busy && (div_cnt_q == '0);
    assign fifo_cnt = cnt_q;

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised successor to the team's fixed 8N1 UART transmitter. It adds a run-time baud divisor, a configurable character length (5..DATA_W), optional even/odd parity, and 1 or 2 stop bits. A valid/ready input port feeds a 2^FIFO_AW-deep transmit FIFO, so frames go out back-to-back with no idle gap. The block sits between a byte-producing controller (e.g. dual-port RAM readout) and the rs232 TX pin.

Parameters:
DATA_W, 8, maximum character length in bits; legal range 5..15.
DIV_W, 16, width of baud_div.
FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW entries.

Ports:
clk  in  1  system clock.
rst  in  1  reset; one clock domain, synchronous to clk, active-low.
baud_div  in  DIV_W  bit period = baud_div+1 clocks; 0 is treated as 1.
data_bits  in  4  character length; below 5 clamps to 5, above DATA_W clamps to DATA_W.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
stop2  in  1  0 = one stop bit, 1 = two stop bits.
in_data  in  DATA_W  character to send, LSB first; bits at or above data_bits are ignored.
in_valid  in  1  in_data valid.
in_ready  out  1  FIFO not full; combinational from the FIFO count.
tx  out  1  serial line, idle high, registered.
tx_done  out  1  one-cycle pulse at the end of each frame.
busy  out  1  high while the FSM is not in IDLE.
bit_tick  out  1  one-cycle pulse on the first clock of every bit period.
fifo_cnt  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset values (rst low at a clk edge): tx=1, tx_done=0, busy=0, bit_tick=0, fifo_cnt=0, in_ready=1. Reset clears FIFO pointers, FSM (to IDLE), bit counter and divider. Reset mid-frame aborts the frame: tx is 1 after that edge and queued data is discarded.
- Push: a word is accepted on a clk edge where in_valid && in_ready. When the FIFO is full, in_ready=0 and in_valid is ignored; no overwrite occurs.
- Pop: the FSM pops only when the FIFO is non-empty, at the IDLE->START edge or at the STOP-end edge. A push and a pop in the same cycle leave fifo_cnt unchanged. A word pushed into an empty FIFO is popped at the next edge, not the same edge.
- Config latch: baud_div (after the 0->1 substitution), data_bits (after clamping), parity_mode and stop2 are latched on each pop. Changes mid-frame have no effect until the next frame.
- Divider: div_cnt counts 0..baud_div_l, then wraps to 0. bit_tick=1 when div_cnt==0 in any state other than IDLE. A bit ends on the edge where div_cnt==baud_div_l.
- FSM states:
  - IDLE: tx=1. If FIFO is non-empty, pop, go to START, tx=0 from this edge.
  - START: one bit period, tx=0, then go to DATA with tx=shift[0].
  - DATA: emit data_bits_l bits LSB first, one period each. Bit index runs 0..data_bits_l-1. After the last bit go to PARITY if parity is enabled, else STOP.
  - PARITY: tx = XOR of the sent data bits for even parity, inverted for odd. One period, then STOP.
  - STOP: tx=1 for 1 or 2 periods. At the final end-of-bit edge, tx_done=1 for one cycle. If the FIFO is non-empty, pop and enter START on that same edge (tx=0 with no idle gap). Otherwise go to IDLE.
- Latency: push accepted at edge E into an empty, idle block gives tx=0 from edge E+1. Frame length = (1 + data_bits_l + parity_en + 1 + stop2) × (baud_div_l+1) clocks.
- Parity is computed only over the data_bits_l transmitted bits.
- busy=1 from the IDLE->START edge until the return to IDLE.

Test Plan:
1. baud_div=3, data_bits=8, parity none, stop2=0, push 8'hA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks total); tx_done pulses once as the 40th clock ends; busy falls with it.
2. Parity: baud_div=1, push 8'h07 with even parity -> parity bit 1; repeat with odd -> parity bit 0; frame is 11 bits × 2 clocks.
3. data_bits=5, stop2=1, push 8'hFF -> start, five 1s, two stop 1s (8 bits); data_bits=2 clamps to 5; baud_div=0 behaves as 1.
4. FIFO_AW=2, baud_div=7: push 6 words back-to-back -> in_ready drops when fifo_cnt=4; 4 or 5 words are accepted per pop timing; frames go out back-to-back with tx_done between them and no idle cycle.
5. Change baud_div and parity mid-frame -> the current frame is unaffected; the next frame uses the new values.
6. Assert rst low mid-DATA with 3 words queued -> next edge tx=1, fifo_cnt=0, busy=0; no further frames are sent after rst returns high.
